// File: rtl/uart_word_if.sv
// Word handshake between the core and the UART word transmitter.
interface uart_word_if;
  logic [23:0] word_in;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/uart_word_tx.sv
// 24-bit word UART transmitter: small word FIFO feeding an 8N1 serializer that
// sends each word as three bytes, most significant byte first, LSB-first bits.
module uart_word_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_word_if.slave                  word_if,
  output logic                        UART_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0]  FullCnt  = CntW'(FIFO_DEPTH);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [23:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [23:0]      shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             active_q, active_d;
  logic             push, pop, baud_end;
  logic [7:0]       cur_byte;

  // A full FIFO blocks pushes even when a pop happens in the same cycle.
  assign word_if.word_ready = (count_q != FullCnt);
  assign push       = word_if.word_valid && word_if.word_ready;
  assign baud_end   = (baud_q == BaudLast);
  assign cur_byte   = shreg_q[23:16];
  assign UART_tx    = tx_q;
  assign fifo_count = count_q;
  // active_q stretches busy one cycle so it covers the registered stop bit.
  assign busy       = (count_q != '0) || (state_q != StIdle) || active_q;

  // FIFO storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word_if.word_in;
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Serializer FSM: frame sequencing, baud timing and FIFO pops.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          byte_d  = 2'd0;
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q != 2'd2) begin
            byte_d  = byte_q + 2'd1;
            shreg_d = {shreg_q[15:0], 8'h00};
            state_d = StStart;
          end else if (count_q != '0) begin
            // Back-to-back words: no idle cycle between frames.
            pop     = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
            byte_d  = 2'd0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the current state; registered so UART_tx is glitch-free.
  always_comb begin
    tx_d     = 1'b1;
    active_d = (state_q != StIdle);
    unique case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers with asynchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      byte_q   <= 2'd0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      active_q <= active_d;
    end
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- UART transmitter for the CPU's 24-bit word link, the return direction of the UART program loader.
- Accepts 24-bit words from the core (debug, register dump, memory readback) through a valid/ready handshake.
- Buffers the words in a small FIFO and serializes each word as three 8N1 bytes on UART_tx.
- Byte order matches the loader framing: bits [23:16] first, then [15:8], then [7:0].

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud).
- FIFO_DEPTH, 4, number of 24-bit words buffered; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- word_in  input  24  word to transmit.
- word_valid  input  1  word_in is valid this cycle.
- word_ready  output  1  FIFO can accept a word; high when the FIFO is not full.
- UART_tx  output  1  serial line, idle high, registered.
- busy  output  1  high when a frame is in progress or the FIFO is not empty.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of words currently buffered.

Behaviour:
- Reset (async assert, sync release):
  - UART_tx=1, busy=0, word_ready=1, fifo_count=0.
  - FIFO pointers cleared, FSM in IDLE, baud counter 0.
- Reset mid-frame aborts the frame: UART_tx returns to 1 immediately and buffered words are discarded.
- Push: the FIFO writes word_in on a rising edge where word_valid && word_ready.
  - word_ready = (fifo_count != FIFO_DEPTH), combinational from the count.
  - A push while full is ignored with no corruption. The push is blocked even if a pop happens in the same cycle.
- Pop: the FSM pops one word on the edge it leaves IDLE and loads it into a 24-bit shift register.
- Simultaneous push and pop when not full: fifo_count is unchanged and both operations complete.
- FSM states and transitions:
  - IDLE: if the FIFO is not empty, pop, set byte_idx=0, go to START.
  - START: UART_tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: UART_tx = current byte bit[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: UART_tx=1 for CLKS_PER_BIT cycles, then:
    - byte_idx<2: increment byte_idx, go to START for the next byte.
    - byte_idx==2 and FIFO not empty: pop the next word, go to START.
    - Otherwise: go to IDLE.
- Current byte selection: byte_idx 0 -> [23:16], 1 -> [15:8], 2 -> [7:0].
- Timing:
  - Every bit lasts exactly CLKS_PER_BIT cycles; the baud counter counts 0..CLKS_PER_BIT-1 and wraps.
  - No idle gap between bytes of a word, and none between back-to-back words.
  - One byte = 10*CLKS_PER_BIT cycles; one word = 30*CLKS_PER_BIT = 26040 cycles at the default.
- Latency: a word pushed at edge N into an empty FIFO while IDLE pops at edge N+1. UART_tx is low after edge N+2. The FSM pops and loads at N+1, and the registered tx drives the start bit at N+2.
- busy is high from the push edge until the last stop bit of the last buffered word completes.
- Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.

Test Plan:
1. Reset, then push 0x0000FF with the line idle → bytes 0x00, 0x00, 0xFF decoded by a bench UART receiver. The start bit falls 2 cycles after the push, and the frame lasts 26040 cycles.
2. Push 0xF0006C and 0xACF28F back-to-back → 6 bytes F0 00 6C AC F2 8F, no gap between the stop bit of 6C and the start bit of AC, and busy falls after the last stop bit.
3. Push 6 words without waiting → word_ready drops once the 4 buffered words plus the word in flight are taken. Push attempts while full are ignored, fifo_count never exceeds 4, and the accepted words are sent in order.
4. Assert rst during the data bits of the second byte of 0x00F0FF → UART_tx=1 in the same cycle, fifo_count=0, busy=0. A fresh push of 0x123456 afterwards is sent cleanly.
5. Bit timing check on 0x555555 → every line transition is spaced by a multiple of exactly 868 cycles, and the stop bit measures 868 cycles high.
6. Push and pop in the same cycle with fifo_count=2 → fifo_count stays 2 and the pushed word is sent after the older buffered word.
